// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the control stage and the
// execute stage, plus the execute-stage FSM state type.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_MUL = 4'b1100
  } alu_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, XLEN
// steps, low XLEN bits of the product. done pulses for one cycle once the
// product is final.
module alu_mul_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            busy;

  // Load operands on start, then add/shift once per cycle until XLEN steps done
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(XLEN - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops register their result the cycle after accept.
// Optional macro ALU_EXEC_MUL_EN adds an iterative multiplier (code 1100);
// without it code 1100 is reported as illegal and the FSM is IDLE only.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  assign accept = in_valid && in_ready;

  // Single-cycle datapath: logic, arithmetic, compare and shifts
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      ALU_SRA: alu_res = $signed(op_a) >>> op_b[4:0];
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL: alu_res = '0;
`endif
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  alu_state_e      state;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign mul_start = accept && (alu_ctrl == ALU_MUL);
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);

  alu_mul_seq #(
    .XLEN(XLEN)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered outputs; MUL parks in MUL_BUSY until done
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state     <= ST_MUL_BUSY;
            out_valid <= 1'b0;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= alu_ill;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= mul_product;
            zero      <= (mul_product == '0);
            illegal   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  // With only the IDLE state the state register folds away entirely
  assign in_ready = !out_valid || out_ready;

  // Output register: load on accept, clear valid once consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec (XLEN=32). Honours ALU_EXEC_MUL_EN the
// same way as the design so either build can be checked.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference: what the operation means arithmetically
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    r   = 32'd0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd6:  r = a - b;
      4'd7:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd12: begin
`ifdef ALU_EXEC_MUL_EN
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        lat = 33;
`else
        ill = 1'b1;
`endif
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Present one op with out_ready=1 and collect the first valid result
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic acc, output int lat, output logic [31:0] r,
                       output logic z, output logic il);
    in_valid  = 1'b1;
    alu_ctrl  = op;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    #1;
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    z  = zero;
    il = illegal;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; alu_ctrl = 4'd0; op_a = '0; op_b = '0; out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, result, zero, illegal} !== 35'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b r=%h z=%b i=%b want all zero", out_valid, result, zero, illegal);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [6] = '{4'd2, 4'd6, 4'd7, 4'd10, 4'd9, 4'd12};
    logic [31:0] as  [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [6] = '{32'd1, 32'd5, 32'd1, 32'd4, 32'd4, 32'd3};
    logic [31:0] ks  [6] = '{32'h80000000, 32'd0, 32'd1, 32'hF8000000, 32'h08000000, 32'hFFFFFFFD};
    logic acc, z, il, eil;
    int lat, elat;
    logic [31:0] r, er;
    for (int i = 0; i < 6; i++) begin
      model(ops[i], as[i], bs[i], er, eil, elat);
      if (!eil) er = ks[i];
      issue(ops[i], as[i], bs[i], acc, lat, r, z, il);
      total++;
      if (acc !== 1'b1 || lat != elat || r !== er || z !== (er == 0) || il !== eil) begin
        bad++;
        $display("FAIL directed_%0d op=%h: got acc=%b lat=%0d r=%h z=%b i=%b want acc=1 lat=%0d r=%h z=%b i=%b",
                 i, ops[i], acc, lat, r, z, il, elat, er, (er == 0), eil);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b, r, er;
    logic acc, z, il, eil;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ((i % 7) == 0) b = a;
      if ((i % 11) == 0) a = 32'h80000000;
      model(op, a, b, er, eil, elat);
      issue(op, a, b, acc, lat, r, z, il);
      total++;
      if (acc !== 1'b1 || lat != elat || r !== er || z !== (er == 0) || il !== eil) begin
        bad++;
        $display("FAIL random_%0d op=%h a=%h b=%h: got acc=%b lat=%0d r=%h z=%b i=%b want lat=%0d r=%h z=%b i=%b",
                 i, op, a, b, acc, lat, r, z, il, elat, er, (er == 0), eil);
      end
    end
  endtask

  task automatic test_mul_stall();
`ifdef ALU_EXEC_MUL_EN
    in_valid = 1'b1; alu_ctrl = 4'd12; op_a = 32'hFFFFFFFF; op_b = 32'd3; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mul_accept: in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    // Changing inputs while busy must not disturb the multiply
    alu_ctrl = 4'd2; op_a = 32'h12345678; op_b = 32'h1;
    for (int k = 0; k < 32; k++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy_%0d: got in_ready=%b out_valid=%b want 0 0", k, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mul_early: out_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'hFFFFFFFD || zero !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL mul_result: got v=%b r=%h z=%b i=%b want 1 fffffffd 0 0", out_valid, result, zero, illegal);
    end
    @(posedge clk); #1;
`else
    logic acc, z, il;
    int lat;
    logic [31:0] r;
    issue(4'd12, 32'hFFFFFFFF, 32'd3, acc, lat, r, z, il);
    total++;
    if (acc !== 1'b1 || lat != 1 || r !== 32'd0 || z !== 1'b1 || il !== 1'b1) begin
      bad++;
      $display("FAIL mul_disabled: got acc=%b lat=%0d r=%h z=%b i=%b want 1 1 0 1 1", acc, lat, r, z, il);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, e1, e2;
    a = $urandom; b = $urandom;
    e1 = a + b;
    e2 = b - a;
    in_valid = 1'b1; alu_ctrl = 4'd2; op_a = a; op_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== e1) begin
      bad++;
      $display("FAIL bp_first: got v=%b r=%h want 1 %h", out_valid, result, e1);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== e1 || zero !== (e1 == 0) || illegal !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: got v=%b r=%h z=%b i=%b rdy=%b want 1 %h %b 0 0",
                 k, out_valid, result, zero, illegal, in_ready, e1, (e1 == 0));
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; alu_ctrl = 4'd6; op_a = b; op_b = a;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== e2) begin
      bad++;
      $display("FAIL bp_next: got v=%b r=%h want 1 %h", out_valid, result, e2);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [3:0] op;
    logic [31:0] a, b, er;
    logic eil;
    int elat;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = codes[$urandom_range(0, 8)];
      a = $urandom; b = $urandom;
      model(op, a, b, er, eil, elat);
      in_valid = 1'b1; alu_ctrl = op; op_a = a; op_b = b;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== er || illegal !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d op=%h: got v=%b r=%h i=%b want 1 %h 0", i, op, out_valid, result, illegal, er);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    in_valid = 1'b1; alu_ctrl = 4'd12; op_a = $urandom; op_b = $urandom; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset_quiet_%0d: got v=%b rdy=%b want 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_stall();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, the operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  the operation on the in_* and operand ports is valid.
REQ-005 in_ready  output  1  the block can accept an operation this cycle.
REQ-006 alu_ctrl  input  4  the operation code from the ALU control stage.
REQ-007 op_a  input  XLEN  first operand.
REQ-008 op_b  input  XLEN  second operand; bits [4:0] are the shift amount.
REQ-009 out_valid  output  1  result, zero and illegal are valid.
REQ-010 out_ready  input  1  the consumer accepts the result this cycle.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  set when result == 0; used for branch decisions.
REQ-013 illegal  output  1  set when alu_ctrl held an unsupported code.

Function
REQ-014 The accept condition SHALL be in_valid && in_ready; operands and alu_ctrl SHALL be captured only on accept.
REQ-015 in_ready SHALL be high only when state == IDLE and (out_valid == 0 or out_ready == 1).
REQ-016 The codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low XLEN bits).
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^XLEN; SLT SHALL return 1 or 0 zero-extended.
REQ-018 Single-cycle ops SHALL assert out_valid on the cycle after accept, with result registered.
REQ-019 An unsupported code SHALL produce result = 0, zero = 1 and illegal = 1, with single-cycle latency.
REQ-020 The FSM states SHALL be IDLE and MUL_BUSY.
REQ-021 IDLE SHALL go to MUL_BUSY on accept of MUL.
REQ-022 MUL_BUSY SHALL perform one shift-add step per cycle for XLEN cycles, then return to IDLE.
REQ-023 The block SHALL assert out_valid XLEN+1 cycles after a MUL accept.
REQ-024 While out_valid && !out_ready, result, zero and illegal SHALL hold stable.
REQ-025 out_valid SHALL drop the cycle after out_ready, unless a new accept occurs in the same cycle (back-to-back throughput of 1 op/cycle for single-cycle ops).
REQ-026 in_valid, alu_ctrl and operand changes during MUL_BUSY SHALL have no effect.

Reset
REQ-027 On reset the block SHALL set state = IDLE, out_valid = 0, result = 0, zero = 0, illegal = 0 and clear the multiplier iteration counter.
REQ-028 Reset asserted mid-MUL SHALL abort the operation with no result emitted; in_ready SHALL be high the cycle after reset deasserts.

Configuration
REQ-029 The macro ALU_EXEC_MUL_EN SHALL control multiply support.
REQ-030 When ALU_EXEC_MUL_EN is defined, code 1100 SHALL be MUL as specified above.
REQ-031 When ALU_EXEC_MUL_EN is undefined, code 1100 SHALL be treated as illegal (REQ-019), MUL_BUSY and the multiplier datapath SHALL be absent, and the FSM SHALL reduce to IDLE only.

Structure
REQ-032 The alu_ctrl code constants (an enum typedef) and the FSM state typedef SHALL live in the shared package alu_pkg, which the ALU control stage also imports.
REQ-033 The iterative multiplier SHALL be the sub-module alu_mul_seq (start, done, operands, product); the shift and logic datapath stays in alu_exec.

Verification
REQ-034 ADD: op_a=0x7FFFFFFF, op_b=1, accept -> next cycle out_valid=1, result=0x80000000, zero=0.
REQ-035 SUB: op_a=5, op_b=5 -> result=0, zero=1. SLT: op_a=0xFFFFFFFF, op_b=1 -> result=1.
REQ-036 SRA: op_a=0x80000000, op_b=4 -> result=0xF8000000. SRL with the same operands -> result=0x08000000.
REQ-037 MUL with the macro defined: op_a=0xFFFFFFFF, op_b=3 -> in_ready=0 for 32 cycles, out_valid at cycle 33, result=0xFFFFFFFD. Without the macro, the same stimulus -> illegal=1, result=0 after 1 cycle.
REQ-038 Back-pressure: hold out_ready=0 for 5 cycles after an ADD result -> result stable and in_ready=0; then out_ready=1 with a new in_valid -> accepted in the same cycle.
REQ-039 Reset asserted during cycle 10 of a MUL -> out_valid stays 0 and in_ready=1 the cycle after reset deasserts.
